// File: rtl/dac_wavegen.sv
// dac_wavegen: ramp / triangle / square / constant DAC code generator with a
// programmable step, a tick prescaler, shadowed configuration applied at period
// boundaries, and a period-end strobe.
// Optional burst mode: define DAC_WAVEGEN_BURST_EN to stop after burst_len periods.
module dac_wavegen #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 16,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   enable,
    input  logic                   start,
    input  logic                   cfg_load,
    input  logic [1:0]             cfg_mode,
    input  logic [DATA_WIDTH-1:0]  cfg_limit,
    input  logic [DATA_WIDTH-1:0]  cfg_step,
    input  logic [PRESC_WIDTH-1:0] cfg_div,
    input  logic [BURST_WIDTH-1:0] burst_len,
    output logic [DATA_WIDTH-1:0]  data,
    output logic                   period_end,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] MODE_RAMP   = 2'd0;
    localparam logic [1:0] MODE_TRI    = 2'd1;
    localparam logic [1:0] MODE_SQUARE = 2'd2;
    localparam logic [1:0] MODE_CONST  = 2'd3;

    localparam logic [DATA_WIDTH:0]    HOLD_ONE  = {{DATA_WIDTH{1'b0}}, 1'b1};
    localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = {{(PRESC_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
`ifdef DAC_WAVEGEN_BURST_EN
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
`else
        ST_PAUSE = 2'd2
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   pe_q, pe_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic                   dir_up_q, dir_up_d;
    logic                   sq_high_q, sq_high_d;
    logic [DATA_WIDTH-1:0]  hold_q, hold_d;

    // Shadow config (written by cfg_load) and active config (drives the waveform).
    logic [1:0]             sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
    logic [DATA_WIDTH-1:0]  sh_limit_q, sh_limit_d, act_limit_q, act_limit_d;
    logic [DATA_WIDTH-1:0]  sh_step_q, sh_step_d, act_step_q, act_step_d;
    logic [PRESC_WIDTH-1:0] sh_div_q, sh_div_d, act_div_q, act_div_d;

    logic                   advance;
    logic                   tick;
    logic                   apply_cfg;
    logic [1:0]             new_mode;
    logic [DATA_WIDTH-1:0]  new_limit, new_step;
    logic [PRESC_WIDTH-1:0] new_div;
    logic [DATA_WIDTH:0]    sum;
    logic [DATA_WIDTH:0]    lim_ext;
    logic [DATA_WIDTH:0]    hold_inc;
    logic [DATA_WIDTH:0]    half;

`ifdef DAC_WAVEGEN_BURST_EN
    localparam logic [BURST_WIDTH-1:0] BURST_ONE = {{(BURST_WIDTH-1){1'b0}}, 1'b1};
    logic [BURST_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
    logic                   burst_hit;
`endif

    // Next-state logic: FSM transitions, prescaler, waveform arithmetic, config transfer.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        pe_d        = 1'b0;
        presc_d     = presc_q;
        dir_up_d    = dir_up_q;
        sq_high_d   = sq_high_q;
        hold_d      = hold_q;
        sh_mode_d   = sh_mode_q;
        sh_limit_d  = sh_limit_q;
        sh_step_d   = sh_step_q;
        sh_div_d    = sh_div_q;
        act_mode_d  = act_mode_q;
        act_limit_d = act_limit_q;
        act_step_d  = act_step_q;
        act_div_d   = act_div_q;
        tick        = 1'b0;
        apply_cfg   = 1'b0;
        advance     = (state_q == ST_RUN) && enable && start;
        sum         = {1'b0, data_q} + {1'b0, act_step_q};
        lim_ext     = {1'b0, act_limit_q};
        hold_inc    = {1'b0, hold_q} + HOLD_ONE;
        half        = (act_step_q == '0) ? HOLD_ONE : {1'b0, act_step_q};
`ifdef DAC_WAVEGEN_BURST_EN
        burst_cnt_d = burst_cnt_q;
        burst_hit   = 1'b0;
`endif

        if (cfg_load) begin
            sh_mode_d  = cfg_mode;
            sh_limit_d = cfg_limit;
            sh_step_d  = cfg_step;
            sh_div_d   = cfg_div;
        end

        if (advance) begin
            // >= rather than == so a smaller div taking effect mid-count cannot overrun
            if (presc_q >= act_div_q) begin
                tick    = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end

            if (tick) begin
                case (act_mode_q)
                    MODE_RAMP: begin
                        if (data_q >= act_limit_q) begin
                            data_d = '0;
                            pe_d   = 1'b1;
                        end else if (sum >= lim_ext) begin
                            data_d = act_limit_q;
                        end else begin
                            data_d = sum[DATA_WIDTH-1:0];
                        end
                    end
                    MODE_TRI: begin
                        // A zero step freezes the triangle completely, direction included
                        if (act_step_q != '0) begin
                            if (dir_up_q) begin
                                if (sum >= lim_ext) begin
                                    data_d   = act_limit_q;
                                    dir_up_d = 1'b0;
                                end else begin
                                    data_d = sum[DATA_WIDTH-1:0];
                                end
                            end else if (data_q <= act_step_q) begin
                                data_d   = '0;
                                dir_up_d = 1'b1;
                                pe_d     = 1'b1;
                            end else begin
                                data_d = data_q - act_step_q;
                            end
                        end
                    end
                    MODE_SQUARE: begin
                        if (hold_inc >= half) begin
                            hold_d = '0;
                            if (sq_high_q) begin
                                data_d    = '0;
                                sq_high_d = 1'b0;
                                pe_d      = 1'b1;
                            end else begin
                                data_d    = act_limit_q;
                                sq_high_d = 1'b1;
                            end
                        end else begin
                            hold_d = hold_inc[DATA_WIDTH-1:0];
                        end
                    end
                    MODE_CONST: begin
                        data_d = act_limit_q;
                    end
                    default: ;
                endcase
            end

            // While running, new config only takes effect at a period boundary
            if (pe_d) begin
                apply_cfg = 1'b1;
            end

`ifdef DAC_WAVEGEN_BURST_EN
            if (pe_d) begin
                burst_cnt_d = burst_cnt_q + BURST_ONE;
                if ((burst_len != '0) && (burst_cnt_d == burst_len)) begin
                    burst_hit = 1'b1;
                    data_d    = '0;
                end
            end
`endif
        end

        if ((state_q == ST_IDLE) || (state_q == ST_PAUSE)) begin
            apply_cfg = 1'b1;
        end

        // When stopped, a cfg_load on this edge passes straight through to active
        new_mode  = (cfg_load && (state_q != ST_RUN)) ? cfg_mode  : sh_mode_q;
        new_limit = (cfg_load && (state_q != ST_RUN)) ? cfg_limit : sh_limit_q;
        new_step  = (cfg_load && (state_q != ST_RUN)) ? cfg_step  : sh_step_q;
        new_div   = (cfg_load && (state_q != ST_RUN)) ? cfg_div   : sh_div_q;

        if (apply_cfg) begin
            act_mode_d  = new_mode;
            act_limit_d = new_limit;
            act_step_d  = new_step;
            act_div_d   = new_div;
            // Mode change: data carries on, direction/phase restart from data
            if (new_mode != act_mode_q) begin
                dir_up_d  = 1'b1;
                sq_high_d = (data_d != '0);
                hold_d    = '0;
            end
        end

        if (!enable) begin
            state_d   = ST_IDLE;
            data_d    = '0;
            pe_d      = 1'b0;
            presc_d   = '0;
            dir_up_d  = 1'b1;
            sq_high_d = 1'b0;
            hold_d    = '0;
`ifdef DAC_WAVEGEN_BURST_EN
            burst_cnt_d = '0;
`endif
        end else begin
            case (state_q)
`ifdef DAC_WAVEGEN_BURST_EN
                ST_DONE: state_d = ST_DONE;
`endif
                default: state_d = start ? ST_RUN : ST_PAUSE;
            endcase
`ifdef DAC_WAVEGEN_BURST_EN
            if (burst_hit) begin
                state_d = ST_DONE;
            end
`endif
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            pe_q        <= 1'b0;
            presc_q     <= '0;
            dir_up_q    <= 1'b1;
            sq_high_q   <= 1'b0;
            hold_q      <= '0;
            sh_mode_q   <= MODE_RAMP;
            sh_limit_q  <= '0;
            sh_step_q   <= '0;
            sh_div_q    <= '0;
            act_mode_q  <= MODE_RAMP;
            act_limit_q <= '0;
            act_step_q  <= '0;
            act_div_q   <= '0;
`ifdef DAC_WAVEGEN_BURST_EN
            burst_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            pe_q        <= pe_d;
            presc_q     <= presc_d;
            dir_up_q    <= dir_up_d;
            sq_high_q   <= sq_high_d;
            hold_q      <= hold_d;
            sh_mode_q   <= sh_mode_d;
            sh_limit_q  <= sh_limit_d;
            sh_step_q   <= sh_step_d;
            sh_div_q    <= sh_div_d;
            act_mode_q  <= act_mode_d;
            act_limit_q <= act_limit_d;
            act_step_q  <= act_step_d;
            act_div_q   <= act_div_d;
`ifdef DAC_WAVEGEN_BURST_EN
            burst_cnt_q <= burst_cnt_d;
`endif
        end
    end

    assign data       = data_q;
    assign period_end = pe_q;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_PAUSE);

`ifdef DAC_WAVEGEN_BURST_EN
    assign done = (state_q == ST_DONE);
`else
    logic unused_burst_len;
    assign unused_burst_len = ^burst_len;
    assign done = 1'b0;
`endif

endmodule

// File: tb/tb_dac_wavegen.sv
// Directed, table-driven bench for dac_wavegen, plus hand-written sequences for
// pause/resume, asynchronous reset and (when DAC_WAVEGEN_BURST_EN is defined) burst.
module tb_dac_wavegen;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        enable, start, cfg_load;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_limit, cfg_step;
    logic [15:0] cfg_div;
    logic [7:0]  burst_len;
    logic [7:0]  data;
    logic        period_end, busy, done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        en;
        logic        st;
        logic        ld;
        logic [1:0]  mode;
        logic [7:0]  lim;
        logic [7:0]  stp;
        logic [15:0] div;
        logic [7:0]  exp_data;
        logic        exp_pe;
        logic        exp_busy;
    } vec_t;

    vec_t vt[$];

    always #5 clk = ~clk;

    dac_wavegen dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .enable     (enable),
        .start      (start),
        .cfg_load   (cfg_load),
        .cfg_mode   (cfg_mode),
        .cfg_limit  (cfg_limit),
        .cfg_step   (cfg_step),
        .cfg_div    (cfg_div),
        .burst_len  (burst_len),
        .data       (data),
        .period_end (period_end),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input int idx, input logic [7:0] d,
                           input logic pe, input logic bz, input logic dn);
        $display("%s[%0d] data=%0d pe=%0b busy=%0b done=%0b", name, idx, data, period_end, busy, done);
        chk({name, ".data"}, idx, 32'(data), 32'(d));
        chk({name, ".pe"},   idx, 32'(period_end), 32'(pe));
        chk({name, ".busy"}, idx, 32'(busy), 32'(bz));
        chk({name, ".done"}, idx, 32'(done), 32'(dn));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic st, input logic ld, input logic [1:0] mode,
                       input logic [7:0] lim, input logic [7:0] stp, input logic [15:0] div,
                       input logic [7:0] d, input logic pe, input logic bz);
        vec_t v;
        v.en = en; v.st = st; v.ld = ld; v.mode = mode; v.lim = lim; v.stp = stp; v.div = div;
        v.exp_data = d; v.exp_pe = pe; v.exp_busy = bz;
        vt.push_back(v);
    endtask

    task automatic run(input logic [7:0] d, input logic pe);
        add(1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 16'd0, d, pe, 1'b1);
    endtask

    task automatic load_idle(input logic [1:0] mode, input logic [7:0] lim,
                             input logic [7:0] stp, input logic [15:0] div);
        enable = 1'b0; start = 1'b0; cfg_load = 1'b1;
        cfg_mode = mode; cfg_limit = lim; cfg_step = stp; cfg_div = div;
        cyc();
        cfg_load = 1'b0;
    endtask

    initial begin
        rst_l = 1'b0; enable = 1'b0; start = 1'b0; cfg_load = 1'b0;
        cfg_mode = 2'd0; cfg_limit = 8'd0; cfg_step = 8'd0; cfg_div = 16'd0; burst_len = 8'd0;
        repeat (2) cyc();
        chk_out("reset", 0, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_l = 1'b1;

        // Ramp 255/73, div 0
        add(1'b0, 1'b0, 1'b1, 2'd0, 8'd255, 8'd73, 16'd0, 8'd0, 1'b0, 1'b0);
        run(8'd0, 1'b0); run(8'd73, 1'b0); run(8'd146, 1'b0); run(8'd219, 1'b0);
        run(8'd255, 1'b0); run(8'd0, 1'b1); run(8'd73, 1'b0);
        // Triangle 250/100, div 0
        add(1'b0, 1'b0, 1'b1, 2'd1, 8'd250, 8'd100, 16'd0, 8'd0, 1'b0, 1'b0);
        run(8'd0, 1'b0); run(8'd100, 1'b0); run(8'd200, 1'b0); run(8'd250, 1'b0);
        run(8'd150, 1'b0); run(8'd50, 1'b0); run(8'd0, 1'b1); run(8'd100, 1'b0);
        // Square 200, half-period 3 ticks, div 1 (tick every 2 clocks)
        add(1'b0, 1'b0, 1'b1, 2'd2, 8'd200, 8'd3, 16'd1, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) run(8'd0, 1'b0);
        for (int i = 0; i < 6; i++) run(8'd200, 1'b0);
        run(8'd0, 1'b1); run(8'd0, 1'b0);
        // Constant 77, div 2: first update div+1 clocks after the first RUN cycle
        add(1'b0, 1'b0, 1'b1, 2'd3, 8'd77, 8'd0, 16'd2, 8'd0, 1'b0, 1'b0);
        run(8'd0, 1'b0); run(8'd0, 1'b0); run(8'd0, 1'b0); run(8'd77, 1'b0); run(8'd77, 1'b0);
        // Reconfig while running: new limit/step take effect after the wrap
        add(1'b0, 1'b0, 1'b1, 2'd0, 8'd255, 8'd73, 16'd0, 8'd0, 1'b0, 1'b0);
        run(8'd0, 1'b0); run(8'd73, 1'b0); run(8'd146, 1'b0);
        add(1'b1, 1'b1, 1'b1, 2'd0, 8'd100, 8'd50, 16'd0, 8'd219, 1'b0, 1'b1);
        run(8'd255, 1'b0); run(8'd0, 1'b1); run(8'd50, 1'b0); run(8'd100, 1'b0);
        run(8'd0, 1'b1); run(8'd50, 1'b0);

        foreach (vt[i]) begin
            enable = vt[i].en; start = vt[i].st; cfg_load = vt[i].ld;
            cfg_mode = vt[i].mode; cfg_limit = vt[i].lim; cfg_step = vt[i].stp; cfg_div = vt[i].div;
            cyc();
            chk_out("vec", i, vt[i].exp_data, vt[i].exp_pe, vt[i].exp_busy, 1'b0);
        end

        // Pause at 146, resume, then drop enable
        load_idle(2'd0, 8'd255, 8'd73, 16'd0);
        enable = 1'b1; start = 1'b1;
        repeat (3) cyc();
        chk_out("pause_pre", 0, 8'd146, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_out("pause_hold", i, 8'd146, 1'b0, 1'b1, 1'b0);
        end
        start = 1'b1;
        cyc();
        chk_out("resume", 0, 8'd146, 1'b0, 1'b1, 1'b0);
        cyc();
        chk_out("resume", 1, 8'd219, 1'b0, 1'b1, 1'b0);
        enable = 1'b0;
        cyc();
        chk_out("disable", 0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while period_end is high
        enable = 1'b1; start = 1'b1;
        repeat (6) cyc();
        chk_out("pre_rst", 0, 8'd0, 1'b1, 1'b1, 1'b0);
        #2;
        rst_l = 1'b0;
        #1;
        chk_out("async_rst", 0, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_l = 1'b1;
        // Config is back to ramp limit 0 step 0: period_end on every tick
        cyc();
        chk_out("lim0", 0, 8'd0, 1'b0, 1'b1, 1'b0);
        cyc();
        chk_out("lim0", 1, 8'd0, 1'b1, 1'b1, 1'b0);
        cyc();
        chk_out("lim0", 2, 8'd0, 1'b1, 1'b1, 1'b0);

`ifdef DAC_WAVEGEN_BURST_EN
        // Burst of two ramp periods
        burst_len = 8'd2;
        load_idle(2'd0, 8'd255, 8'd73, 16'd0);
        enable = 1'b1; start = 1'b1;
        repeat (6) cyc();
        chk_out("burst_p1", 0, 8'd0, 1'b1, 1'b1, 1'b0);
        repeat (5) cyc();
        chk_out("burst_p2", 0, 8'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_out("burst_done", i, 8'd0, 1'b0, 1'b0, 1'b1);
        end
        enable = 1'b0;
        cyc();
        chk_out("burst_clr", 0, 8'd0, 1'b0, 1'b0, 1'b0);
        burst_len = 8'd0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
